wb_summult_regs: RTL and testbench

WB_SUMMULT_REGS -- requirements
Module: wb_summult_regs

---
 rtl/wb_summult_regs.sv | 161 ++++++++++++++++
 tb/tb_wb_summult_regs.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_summult_regs.sv
// wb_summult_regs -- Wishbone register window (CTRL/N/RESULT/STATUS) for a sum/multiply core.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module wb_summult_regs #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] n_o,
  output logic        start_o,
  input  logic [31:0] x_i,
  input  logic        done_i,
  output logic        irq_o
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_N      = 2'd1;
  localparam logic [1:0] REG_RESULT = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic        hit;
  logic        wr_en;
  logic        done_rise;
  logic        unused_bits;

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  req_reg_q, req_reg_d;
  logic        req_we_q, req_we_d;
  logic [1:0]  req_sel_q, req_sel_d;
  logic [15:0] req_dat_q, req_dat_d;
  logic [15:0] n_q, n_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        irq_en_q, irq_en_d;
  logic        start_q, start_d;
  logic        irq_q, irq_d;
  logic        done_prev_q, done_prev_d;

  assign hit         = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign wr_en       = ack_q & req_we_q;
  assign done_rise   = done_i & ~done_prev_q & busy_q;
  assign unused_bits = ^{wbs_dat_i[31:16], wbs_sel_i[3:2], wbs_adr_i[1:0]};

  always_comb begin
    ack_d       = hit & ~ack_q;
    dat_d       = 32'h0;
    req_reg_d   = req_reg_q;
    req_we_d    = req_we_q;
    req_sel_d   = req_sel_q;
    req_dat_d   = req_dat_q;
    n_d         = n_q;
    result_d    = result_q;
    busy_d      = busy_q;
    done_d      = done_q;
    irq_en_d    = irq_en_q;
    start_d     = 1'b0;
    irq_d       = done_q & irq_en_q;
    done_prev_d = done_i;

    // The access is latched at the hit so the write can be applied when the ack completes.
    if (ack_d) begin
      req_reg_d = wbs_adr_i[3:2];
      req_we_d  = wbs_we_i;
      req_sel_d = wbs_sel_i[1:0];
      req_dat_d = wbs_dat_i[15:0];
      case (wbs_adr_i[3:2])
        REG_CTRL:   dat_d = {29'h0, irq_en_q, done_q, busy_q};
        REG_N:      dat_d = {16'h0, n_q};
        REG_RESULT: dat_d = result_q;
        default:    dat_d = {31'h0, done_q};
      endcase
    end

    if (wr_en) begin
      case (req_reg_q)
        REG_CTRL: begin
          if (req_sel_q[0]) begin
            irq_en_d = req_dat_q[1];
            if (req_dat_q[0] && !busy_q) begin
              start_d = 1'b1;
              busy_d  = 1'b1;
              done_d  = 1'b0;
            end
          end
        end
        REG_N: begin
          if (!busy_q) begin
            if (req_sel_q[0]) n_d[7:0]  = req_dat_q[7:0];
            if (req_sel_q[1]) n_d[15:8] = req_dat_q[15:8];
          end
        end
        REG_STATUS: begin
          if (req_dat_q[0]) done_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Completion is evaluated after the STATUS clear so a coincident set wins.
    if (done_rise) begin
      result_d = x_i;
      busy_d   = 1'b0;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q       <= 1'b0;
      dat_q       <= 32'h0;
      req_reg_q   <= 2'd0;
      req_we_q    <= 1'b0;
      req_sel_q   <= 2'd0;
      req_dat_q   <= 16'h0;
      n_q         <= 16'h0;
      result_q    <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      start_q     <= 1'b0;
      irq_q       <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      req_reg_q   <= req_reg_d;
      req_we_q    <= req_we_d;
      req_sel_q   <= req_sel_d;
      req_dat_q   <= req_dat_d;
      n_q         <= n_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      irq_en_q    <= irq_en_d;
      start_q     <= start_d;
      irq_q       <= irq_d;
      done_prev_q <= done_prev_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign n_o       = n_q;
  assign start_o   = start_q;
  assign irq_o     = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_summult_regs.sv
// tb_wb_summult_regs -- directed self-checking bench for wb_summult_regs with a transaction-level model.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_wb_summult_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [15:0] n_o;
  logic        start_o;
  logic [31:0] x_i = 32'h0;
  logic        done_i = 1'b0;
  logic        irq_o;

  always #5 clk = ~clk;

  wb_summult_regs #(.BASE_ADR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .n_o(n_o), .start_o(start_o), .x_i(x_i), .done_i(done_i), .irq_o(irq_o)
  );

  int checks = 0;
  int failures = 0;

  // Model state: what the register block must hold after each completed event.
  logic [15:0] m_n = 16'h0;
  logic [31:0] m_result = 32'h0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_irq_en = 1'b0;
  int          m_starts = 0;
  int          obs_starts = 0;
  bit          chk_en = 1'b0;
  logic        irq_exp = 1'b0;
  logic        start_prev = 1'b0;
  logic [31:0] rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // irq is the model's done&irq_en delayed by one clock.
  always @(posedge clk) irq_exp <= m_done & m_irq_en;

  always @(negedge clk) begin
    if (rst_n) begin
      if (start_o) obs_starts <= obs_starts + 1;
      start_prev <= start_o;
      if (chk_en) begin
        chk("n_o", {16'h0, n_o}, {16'h0, m_n});
        chk("irq_o", {31'h0, irq_o}, {31'h0, irq_exp});
        if (!wbs_ack_o) chk("dat_idle", wbs_dat_o, 32'h0);
        if (start_o) chk("start_width", {31'h0, start_prev}, 32'h0);
      end
    end else begin
      start_prev <= 1'b0;
    end
  end

  task automatic xfer(input bit wr, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input bit raise_done, output logic [31:0] rdat);
    logic [31:0] exp_rd;
    bit acked;
    acked = 1'b0;
    rdat  = 32'h0;
    case (adr[3:2])
      2'd0:    exp_rd = {29'h0, m_irq_en, m_done, m_busy};
      2'd1:    exp_rd = {16'h0, m_n};
      2'd2:    exp_rd = m_result;
      default: exp_rd = {31'h0, m_done};
    endcase
    @(posedge clk); #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = wr;
    wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        acked = 1'b1;
        rdat  = wbs_dat_o;
        if (raise_done) done_i = 1'b1;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    chk("ack_seen", {31'h0, acked}, 32'h1);
    if (acked && !wr) chk("rd_model", rdat, exp_rd);
    @(posedge clk); #1;
    if (acked && wr) begin
      case (adr[3:2])
        2'd0: if (sel[0]) begin
          m_irq_en = dat[1];
          if (dat[0] && !m_busy) begin
            m_busy = 1'b1; m_done = 1'b0; m_starts++;
          end
        end
        2'd1: if (!m_busy) begin
          if (sel[0]) m_n[7:0]  = dat[7:0];
          if (sel[1]) m_n[15:8] = dat[15:8];
        end
        2'd3: if (dat[0]) m_done = 1'b0;
        default: ;
      endcase
    end
    if (acked && raise_done && m_busy) begin
      m_result = x_i; m_busy = 1'b0; m_done = 1'b1;
    end
  endtask

  task automatic complete(input logic [31:0] x);
    @(posedge clk); #1;
    x_i = x; done_i = 1'b1;
    @(posedge clk); #1;
    if (m_busy) begin
      m_result = x; m_busy = 1'b0; m_done = 1'b1;
    end
  endtask

  task automatic drop_done();
    @(posedge clk); #1;
    done_i = 1'b0;
  endtask

  task automatic hold4(input logic [31:0] adr, input logic [3:0] pat, input string nm);
    @(posedge clk); #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF; wbs_adr_i = adr;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk({nm, "_ack"}, {31'h0, wbs_ack_o}, {31'h0, pat[3-i]});
      chk({nm, "_dat"}, wbs_dat_o, pat[3-i] ? m_result : 32'h0);
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    m_n = 16'h0; m_result = 32'h0; m_busy = 1'b0; m_done = 1'b0; m_irq_en = 1'b0;
    #1;
    chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    chk("rst_start", {31'h0, start_o}, 32'h0);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    chk("rst_n_o", {16'h0, n_o}, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Byte-lane gating on N.
    xfer(1, BASE + 32'h4, 32'h0000_ABCD, 4'b0001, 0, rd);
    chk("n_sel0", {16'h0, n_o}, 32'h0000_00CD);
    xfer(1, BASE + 32'h4, 32'h0000_0005, 4'b0011, 0, rd);
    chk("n_5", {16'h0, n_o}, 32'h5);
    xfer(0, BASE + 32'h4, 32'h0, 4'hF, 0, rd);
    chk("rd_n", rd, 32'h5);

    // Start: one pulse the cycle after the ack.
    xfer(1, BASE, 32'h1, 4'hF, 0, rd);
    chk("start_hi", {31'h0, start_o}, 32'h1);
    @(posedge clk); #1;
    chk("start_lo", {31'h0, start_o}, 32'h0);
    xfer(0, BASE, 32'h0, 4'hF, 0, rd);
    chk("ctrl_busy", rd, 32'h1);

    // Writes while busy are dropped.
    xfer(1, BASE, 32'h1, 4'hF, 0, rd);
    xfer(1, BASE + 32'h4, 32'h0000_0009, 4'hF, 0, rd);
    chk("n_busy", {16'h0, n_o}, 32'h5);
    xfer(0, BASE, 32'h0, 4'hF, 0, rd);
    chk("ctrl_busy2", rd, 32'h1);
    chk("starts_1", obs_starts, 1);

    complete(32'h0000_000F);
    drop_done();
    xfer(0, BASE, 32'h0, 4'hF, 0, rd);
    chk("ctrl_done", rd, 32'h2);
    xfer(0, BASE + 32'h8, 32'h0, 4'hF, 0, rd);
    chk("result_f", rd, 32'hF);
    xfer(1, BASE + 32'h8, 32'h1234, 4'hF, 0, rd);
    xfer(0, BASE + 32'h8, 32'h0, 4'hF, 0, rd);
    chk("result_ro", rd, 32'hF);
    xfer(1, BASE + 32'hC, 32'h1, 4'hF, 0, rd);
    xfer(0, BASE + 32'hC, 32'h0, 4'hF, 0, rd);
    chk("status_clr", rd, 32'h0);

    // Interrupt timing.
    xfer(1, BASE, 32'h2, 4'hF, 0, rd);
    xfer(0, BASE, 32'h0, 4'hF, 0, rd);
    chk("ctrl_irqen", rd, 32'h4);
    xfer(1, BASE, 32'h3, 4'hF, 0, rd);
    complete(32'h0000_001E);
    chk("irq_lag", {31'h0, irq_o}, 32'h0);
    @(posedge clk); #1;
    chk("irq_set", {31'h0, irq_o}, 32'h1);
    drop_done();
    xfer(1, BASE + 32'hC, 32'h0, 4'hF, 0, rd);
    xfer(0, BASE + 32'hC, 32'h0, 4'hF, 0, rd);
    chk("status_w0", rd, 32'h1);
    xfer(1, BASE + 32'hC, 32'h1, 4'hF, 0, rd);
    chk("irq_hold", {31'h0, irq_o}, 32'h1);
    @(posedge clk); #1;
    chk("irq_clr", {31'h0, irq_o}, 32'h0);

    // Idle done edge is ignored.
    complete(32'h0000_0055);
    xfer(0, BASE + 32'h8, 32'h0, 4'hF, 0, rd);
    chk("idle_edge", rd, 32'h1E);

    // done_i already high at start is not a completion.
    xfer(1, BASE, 32'h3, 4'hF, 0, rd);
    repeat (3) @(posedge clk);
    #1;
    xfer(0, BASE, 32'h0, 4'hF, 0, rd);
    chk("rearm_busy", rd, 32'h5);
    drop_done();
    complete(32'h0000_0077);
    drop_done();
    xfer(0, BASE + 32'h8, 32'h0, 4'hF, 0, rd);
    chk("rearm_res", rd, 32'h77);

    // Completion and STATUS clear in the same cycle: set wins.
    xfer(1, BASE + 32'hC, 32'h1, 4'hF, 0, rd);
    xfer(1, BASE, 32'h3, 4'hF, 0, rd);
    x_i = 32'h0000_0099;
    xfer(1, BASE + 32'hC, 32'h1, 4'hF, 1, rd);
    drop_done();
    xfer(0, BASE + 32'hC, 32'h0, 4'hF, 0, rd);
    chk("set_wins", rd, 32'h1);

    // Held strobe acks alternately; out-of-window never acks.
    hold4(BASE + 32'h8, 4'b1010, "hold");
    hold4(32'h3000_0100, 4'b0000, "miss");

    // Reset mid-operation abandons the computation.
    xfer(1, BASE, 32'h1, 4'hF, 0, rd);
    do_reset();
    complete(32'h0000_DEAD);
    drop_done();
    xfer(0, BASE + 32'h8, 32'h0, 4'hF, 0, rd);
    chk("rst_result", rd, 32'h0);
    xfer(0, BASE, 32'h0, 4'hF, 0, rd);
    chk("rst_ctrl", rd, 32'h0);

    xfer(1, BASE + 32'h4, 32'h3, 4'hF, 0, rd);
    xfer(1, BASE, 32'h1, 4'hF, 0, rd);
    complete(32'h0000_0006);
    drop_done();
    xfer(0, BASE + 32'h8, 32'h0, 4'hF, 0, rd);
    chk("post_rst_res", rd, 32'h6);
    repeat (2) @(posedge clk);
    #1;
    chk("starts_model", obs_starts, m_starts);
    chk("starts_total", obs_starts, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
